// File: rtl/alu_arbiter_if.sv
// Request/response channels of the shared-ALU arbiter and its ALU-side bus.
// The slave modport is the arbiter's view; master is the clients'/ALU's view.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [1:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [1:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_result;
    logic              rsp0_zero;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_result;
    logic              rsp1_zero;

    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_data2;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero,
        output rsp1_valid, rsp1_result, rsp1_zero,
        output alu_data1, alu_data2, alu_op, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero,
        input  rsp1_valid, rsp1_result, rsp1_zero,
        input  alu_data1, alu_data2, alu_op, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters,
// with a registered exec stage and one response slot per requester (2-cycle latency).
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int unsigned OP_W  = 2;
    localparam int unsigned N_REQ = 2;

    logic                 exec_valid;
    logic                 exec_id;
    logic                 last_grant;
    logic [DATA_W-1:0]    data1_q;
    logic [DATA_W-1:0]    data2_q;
    logic [OP_W-1:0]      op_q;
    logic [N_REQ-1:0]     rsp_valid_q;
    logic [N_REQ-1:0]     rsp_zero_q;
    logic [DATA_W-1:0]    rsp_result_q [N_REQ];

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     rsp_ready;
    logic [DATA_W-1:0]    req_a  [N_REQ];
    logic [DATA_W-1:0]    req_b  [N_REQ];
    logic [OP_W-1:0]      req_op [N_REQ];
    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     cand;
    logic [N_REQ-1:0]     grant;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;
    assign req_op[0] = bus.req0_op;
    assign req_op[1] = bus.req1_op;

    // A requester is eligible when it has nothing in flight and its slot can take a result.
    always_comb begin
        eligible = '0;
        cand     = '0;
        grant    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = !(exec_valid && (exec_id == 1'(i))) &&
                          (!rsp_valid_q[i] || rsp_ready[i]);
        end
        cand     = req_valid & eligible;
        grant[0] = cand[0] && (!cand[1] || last_grant);
        grant[1] = cand[1] && (!cand[0] || !last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_valid  <= 1'b0;
            exec_id     <= 1'b0;
            last_grant  <= 1'b1;
            data1_q     <= '0;
            data2_q     <= '0;
            op_q        <= '0;
            rsp_valid_q <= '0;
            rsp_zero_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                rsp_result_q[i] <= '0;
            end
        end else begin
            exec_valid <= |grant;
            if (grant[0]) begin
                data1_q    <= req_a[0];
                data2_q    <= req_b[0];
                op_q       <= req_op[0];
                exec_id    <= 1'b0;
                last_grant <= 1'b0;
            end else if (grant[1]) begin
                data1_q    <= req_a[1];
                data2_q    <= req_b[1];
                op_q       <= req_op[1];
                exec_id    <= 1'b1;
                last_grant <= 1'b1;
            end
            // Refill takes priority over a pop of the same slot.
            for (int i = 0; i < N_REQ; i++) begin
                if (exec_valid && (exec_id == 1'(i))) begin
                    rsp_valid_q[i]  <= 1'b1;
                    rsp_result_q[i] <= bus.alu_result;
                    rsp_zero_q[i]   <= bus.alu_zero;
                end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                    rsp_valid_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.rsp0_valid  = rsp_valid_q[0];
    assign bus.rsp0_result = rsp_result_q[0];
    assign bus.rsp0_zero   = rsp_zero_q[0];
    assign bus.rsp1_valid  = rsp_valid_q[1];
    assign bus.rsp1_result = rsp_result_q[1];
    assign bus.rsp1_zero   = rsp_zero_q[1];
    assign bus.alu_data1   = data1_q;
    assign bus.alu_data2   = data2_q;
    assign bus.alu_op      = op_q;
    assign bus.busy        = exec_valid;
endmodule
